// File: rtl/bibp_pkg.sv
// bibp_pkg: opcode constants and client FSM state encoding for the bibp instruction unit.
package bibp_pkg;
    localparam logic [2:0] TOPLA      = 3'b000;
    localparam logic [2:0] CIKAR      = 3'b001;
    localparam logic [2:0] B_AND      = 3'b010;
    localparam logic [2:0] B_OR       = 3'b011;
    localparam logic [2:0] AND_R      = 3'b100;
    localparam logic [2:0] OR_R       = 3'b101;
    localparam logic [2:0] CIFT_ESLIK = 3'b110;
    localparam logic [2:0] TEK_ESLIK  = 3'b111;
    localparam logic [1:0] BOS        = 2'd0;
    localparam logic [1:0] GONDER     = 2'd1;
    localparam logic [1:0] CEVAP      = 2'd2;
endpackage

// File: rtl/bibp_istemci_fifo.sv
// bibp_istemci_fifo: synchronous power-of-two FIFO with head-of-queue read and async reset.
module bibp_istemci_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/bibp_istemci.sv
// bibp_istemci: in-order request client for the combinational bibp unit.
// Define BIBP_ISTEMCI_SAYAC_EN to enable the completed-response counter.
module bibp_istemci
    import bibp_pkg::*;
#(
    parameter int UZUNLUK       = 6,
    parameter int SIRA_DERINLIK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 istek_gecerli,
    output logic                 istek_hazir,
    input  logic [2:0]           istek_islem,
    input  logic [UZUNLUK-1:0]   istek_a,
    input  logic [UZUNLUK-1:0]   istek_b,
    output logic [UZUNLUK*2+2:0] buyruk,
    input  logic [UZUNLUK:0]     sonuc,
    output logic                 cevap_gecerli,
    input  logic                 cevap_hazir,
    output logic [UZUNLUK:0]     cevap_sonuc,
    output logic [2:0]           cevap_islem,
    output logic [15:0]          islem_sayaci
);
    localparam int W = UZUNLUK*2+3;
    logic [1:0]   durum;
    logic [W-1:0] bas;
    logic         dolu, bos, pop;
    // Ready is forced low during reset so nothing is accepted before release.
    assign istek_hazir   = !dolu && !rst;
    assign cevap_gecerli = durum == CEVAP;
    assign pop           = !bos && (durum == BOS || (durum == CEVAP && cevap_hazir));
    bibp_istemci_fifo #(.WIDTH(W), .DEPTH(SIRA_DERINLIK)) u_sira (
        .clk   (clk),
        .rst   (rst),
        .push  (istek_gecerli && istek_hazir),
        .din   ({istek_islem, istek_a, istek_b}),
        .pop   (pop),
        .dout  (bas),
        .full  (dolu),
        .empty (bos)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum       <= BOS;
            buyruk      <= '0;
            cevap_sonuc <= '0;
            cevap_islem <= '0;
        end else begin
            case (durum)
                BOS: if (!bos) begin
                    buyruk <= bas;
                    durum  <= GONDER;
                end
                GONDER: begin
                    cevap_sonuc <= sonuc;
                    cevap_islem <= buyruk[W-1 -: 3];
                    durum       <= CEVAP;
                end
                CEVAP: if (cevap_hazir) begin
                    durum <= bos ? BOS : GONDER;
                    if (!bos) buyruk <= bas;
                end
                default: durum <= BOS;
            endcase
        end
    end
`ifdef BIBP_ISTEMCI_SAYAC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) islem_sayaci <= '0;
        else if (cevap_gecerli && cevap_hazir) islem_sayaci <= islem_sayaci + 1'b1;
    end
`else
    assign islem_sayaci = 16'h0000;
`endif
endmodule

// File: tb/tb_bibp_istemci.sv
// tb_bibp_istemci: directed checks of bibp_istemci with a behavioural bibp model on buyruk/sonuc.
module tb_bibp_istemci;
    import bibp_pkg::*;
    logic        clk = 0, rst = 1;
    logic        istek_gecerli = 0, istek_hazir;
    logic [2:0]  istek_islem = 0;
    logic [5:0]  istek_a = 0, istek_b = 0;
    logic [14:0] buyruk;
    logic [6:0]  sonuc;
    logic        cevap_gecerli, cevap_hazir = 0;
    logic [6:0]  cevap_sonuc;
    logic [2:0]  cevap_islem;
    logic [15:0] islem_sayaci;
    int checks = 0, errors = 0;

    bibp_istemci #(.UZUNLUK(6), .SIRA_DERINLIK(4)) dut (
        .clk(clk), .rst(rst), .istek_gecerli(istek_gecerli), .istek_hazir(istek_hazir),
        .istek_islem(istek_islem), .istek_a(istek_a), .istek_b(istek_b), .buyruk(buyruk),
        .sonuc(sonuc), .cevap_gecerli(cevap_gecerli), .cevap_hazir(cevap_hazir),
        .cevap_sonuc(cevap_sonuc), .cevap_islem(cevap_islem), .islem_sayaci(islem_sayaci)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] bibp_f(input logic [14:0] w);
        logic [5:0] a, b;
        a = w[11:6];
        b = w[5:0];
        case (w[14:12])
            TOPLA:      return {1'b0, a} + {1'b0, b};
            CIKAR:      return {1'b0, a} - {1'b0, b};
            B_AND:      return {1'b0, a & b};
            B_OR:       return {1'b0, a | b};
            AND_R:      return {6'b0, &b};
            OR_R:       return {6'b0, |b};
            CIFT_ESLIK: return {6'b0, ^b};
            default:    return {6'b0, ~^b};
        endcase
    endfunction

    always_comb sonuc = bibp_f(buyruk);

    task automatic send(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b, output bit ok);
        istek_gecerli = 1;
        istek_islem = op;
        istek_a = a;
        istek_b = b;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = istek_hazir;
            @(negedge clk);
        end
        istek_gecerli = 0;
    endtask

    task automatic wait_resp(output logic [6:0] s, output logic [2:0] op, output bit ok);
        ok = 0;
        s = 'x;
        op = 'x;
        cevap_hazir = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cevap_gecerli) begin
                s = cevap_sonuc;
                op = cevap_islem;
                ok = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (buyruk !== 15'h0) begin errors++; $display("FAIL reset_buyruk got %h want 0", buyruk); end
        checks++; if (cevap_gecerli !== 1'b0) begin errors++; $display("FAIL reset_gecerli got %b want 0", cevap_gecerli); end
        checks++; if (istek_hazir !== 1'b0) begin errors++; $display("FAIL reset_hazir got %b want 0", istek_hazir); end
        checks++; if (islem_sayaci !== 16'h0) begin errors++; $display("FAIL reset_sayac got %h want 0", islem_sayaci); end
        rst = 0;
        @(negedge clk);
        checks++; if (istek_hazir !== 1'b1) begin errors++; $display("FAIL release_hazir got %b want 1", istek_hazir); end
    endtask

    task automatic test_topla;
        cevap_hazir = 0;
        istek_gecerli = 1; istek_islem = TOPLA; istek_a = 6'd5; istek_b = 6'd9;
        @(negedge clk);
        istek_gecerli = 0;
        checks++; if (cevap_gecerli !== 1'b0) begin errors++; $display("FAIL topla_early1 got %b want 0", cevap_gecerli); end
        @(negedge clk);
        checks++; if (buyruk !== 15'h0149) begin errors++; $display("FAIL topla_buyruk got %h want 0149", buyruk); end
        checks++; if (cevap_gecerli !== 1'b0) begin errors++; $display("FAIL topla_early2 got %b want 0", cevap_gecerli); end
        @(negedge clk);
        checks++; if (cevap_gecerli !== 1'b1) begin errors++; $display("FAIL topla_gecerli got %b want 1", cevap_gecerli); end
        checks++; if (cevap_sonuc !== 7'd14) begin errors++; $display("FAIL topla_sonuc got %h want 0e", cevap_sonuc); end
        checks++; if (cevap_islem !== TOPLA) begin errors++; $display("FAIL topla_islem got %b want 000", cevap_islem); end
        @(negedge clk);
        checks++; if ({cevap_gecerli, cevap_sonuc} !== {1'b1, 7'd14}) begin errors++; $display("FAIL topla_hold got %b/%h want 1/0e", cevap_gecerli, cevap_sonuc); end
        cevap_hazir = 1;
        @(negedge clk);
        checks++; if (cevap_gecerli !== 1'b0) begin errors++; $display("FAIL topla_done got %b want 0", cevap_gecerli); end
        checks++; if (buyruk !== 15'h0149) begin errors++; $display("FAIL topla_buyruk_hold got %h want 0149", buyruk); end
    endtask

    task automatic test_cikar_eslik;
        logic [6:0] s;
        logic [2:0] op;
        bit ok, ok2;
        send(CIKAR, 6'd3, 6'd5, ok);
        wait_resp(s, op, ok2);
        checks++; if (!(ok && ok2)) begin errors++; $display("FAIL cikar_timeout got %b%b want 11", ok, ok2); end
        checks++; if (s !== 7'h7E) begin errors++; $display("FAIL cikar_sonuc got %h want 7e", s); end
        checks++; if (op !== CIKAR) begin errors++; $display("FAIL cikar_islem got %b want 001", op); end
        send(TEK_ESLIK, 6'd0, 6'b000111, ok);
        wait_resp(s, op, ok2);
        checks++; if (!(ok && ok2)) begin errors++; $display("FAIL tek_timeout got %b%b want 11", ok, ok2); end
        checks++; if (s !== 7'd0) begin errors++; $display("FAIL tek_sonuc got %h want 00", s); end
        checks++; if (op !== TEK_ESLIK) begin errors++; $display("FAIL tek_islem got %b want 111", op); end
    endtask

    task automatic test_backpressure;
        logic [6:0] got [5];
        int acc = 0, n = 0;
        cevap_hazir = 0;
        for (int i = 0; i < 6; i++) begin
            istek_gecerli = 1; istek_islem = TOPLA; istek_a = 6'(i); istek_b = 6'd10;
            if (istek_hazir) acc++;
            @(negedge clk);
        end
        istek_gecerli = 0;
        checks++; if (acc !== 5) begin errors++; $display("FAIL bp_accepted got %0d want 5", acc); end
        checks++; if (istek_hazir !== 1'b0) begin errors++; $display("FAIL bp_hazir got %b want 0", istek_hazir); end
        cevap_hazir = 1;
        for (int c = 0; c < 40 && n < 5; c++) begin
            if (cevap_gecerli) begin got[n] = cevap_sonuc; n++; end
            @(negedge clk);
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL bp_count got %0d want 5", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got[i] !== 7'(10 + i)) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], 7'(10 + i)); end
        end
        repeat (4) @(negedge clk);
        checks++; if ({cevap_gecerli, istek_hazir} !== 2'b01) begin errors++; $display("FAIL bp_drain got %b%b want 01", cevap_gecerli, istek_hazir); end
    endtask

    task automatic test_streaming;
        logic [2:0] ops [4] = '{B_AND, B_OR, AND_R, OR_R};
        logic [5:0] as [4] = '{6'h3C, 6'h3C, 6'h00, 6'h00};
        logic [5:0] bs [4] = '{6'h0F, 6'h0F, 6'h3F, 6'h00};
        logic [6:0] exp [4] = '{7'h0C, 7'h3F, 7'h01, 7'h00};
        logic [6:0] got_s [4];
        logic [2:0] got_op [4];
        int got_c [4];
        int n = 0;
        cevap_hazir = 1;
        for (int c = 0; c < 20; c++) begin
            if (cevap_gecerli && n < 4) begin got_s[n] = cevap_sonuc; got_op[n] = cevap_islem; got_c[n] = c; n++; end
            if (c < 4) begin
                istek_gecerli = 1; istek_islem = ops[c]; istek_a = as[c]; istek_b = bs[c];
            end else istek_gecerli = 0;
            @(negedge clk);
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL stream_count got %0d want 4", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got_s[i] !== exp[i]) begin errors++; $display("FAIL stream_sonuc[%0d] got %h want %h", i, got_s[i], exp[i]); end
            checks++; if (got_op[i] !== ops[i]) begin errors++; $display("FAIL stream_islem[%0d] got %b want %b", i, got_op[i], ops[i]); end
            checks++; if (got_c[i] !== 3 + 2 * i) begin errors++; $display("FAIL stream_cycle[%0d] got %0d want %0d", i, got_c[i], 3 + 2 * i); end
        end
    endtask

    task automatic test_reset_mid;
        logic [6:0] s;
        logic [2:0] op;
        bit ok, ok2, seen = 0;
        cevap_hazir = 0;
        send(TOPLA, 6'd7, 6'd7, ok);
        send(CIKAR, 6'd9, 6'd1, ok2);
        checks++; if (!(ok && ok2)) begin errors++; $display("FAIL mid_send got %b%b want 11", ok, ok2); end
        send(B_OR, 6'd1, 6'd2, ok);
        for (int i = 0; i < 20 && !cevap_gecerli; i++) @(negedge clk);
        checks++; if (cevap_gecerli !== 1'b1) begin errors++; $display("FAIL mid_cevap got %b want 1", cevap_gecerli); end
        rst = 1;
        #1;
        checks++; if ({buyruk, cevap_gecerli, cevap_sonuc, cevap_islem, islem_sayaci, istek_hazir} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got %h/%b/%h/%b/%h/%b want all 0", buyruk, cevap_gecerli, cevap_sonuc, cevap_islem, islem_sayaci, istek_hazir);
        end
        @(negedge clk);
        rst = 0;
        cevap_hazir = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= cevap_gecerli;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", seen); end
        send(TOPLA, 6'd1, 6'd1, ok);
        wait_resp(s, op, ok2);
        checks++; if ({ok, ok2, s} !== {2'b11, 7'd2}) begin errors++; $display("FAIL mid_after got %b%b/%h want 11/02", ok, ok2, s); end
    endtask

    task automatic test_counter;
        logic [6:0] s;
        logic [2:0] op;
        bit ok, ok2;
        logic [15:0] want;
`ifdef BIBP_ISTEMCI_SAYAC_EN
        want = 16'd3;
`else
        want = 16'd0;
`endif
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++; if (islem_sayaci !== 16'd0) begin errors++; $display("FAIL cnt_start got %h want 0", islem_sayaci); end
        for (int i = 0; i < 3; i++) begin
            send(B_AND, 6'h3F, 6'(i), ok);
            wait_resp(s, op, ok2);
            checks++; if ({ok, ok2, s} !== {2'b11, 7'(i)}) begin errors++; $display("FAIL cnt_resp[%0d] got %b%b/%h want 11/%h", i, ok, ok2, s, 7'(i)); end
        end
        checks++; if (islem_sayaci !== want) begin errors++; $display("FAIL cnt_value got %0d want %0d", islem_sayaci, want); end
    endtask

    initial begin
        test_reset;
        test_topla;
        test_cikar_eslik;
        test_backpressure;
        test_streaming;
        test_reset_mid;
        test_counter;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
